// File: rtl/song_reader_pkg.sv
// ---------------------------------------------------------------------------
// song_reader_pkg : shared widths, markers and state encoding for the player
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package song_reader_pkg;

  localparam int DEF_IDX_W  = 5;
  localparam int DEF_NOTE_W = 6;
  localparam int DEF_DUR_W  = 6;
  localparam int SONG_W     = 2;
  localparam int END_MARKER = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_ROM  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4,
    ST_END       = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/song_note_counter.sv
// ---------------------------------------------------------------------------
// song_note_counter : note index counter with clear, enable and terminal flag
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module song_note_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/song_reader.sv
// ---------------------------------------------------------------------------
// song_reader : walks a song's note list in the external ROM and hands each
//               note to note_player; pulses song_done at the end of the song
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module song_reader
  import song_reader_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W  = DEF_DUR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_play,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    note_done,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic                    new_note,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    song_done
);

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   cur_song_q, cur_song_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                new_note_q, new_note_d;
  logic                song_done_q, song_done_d;

  logic [IDX_W-1:0]    idx;
  logic                idx_last;
  logic                idx_clr;
  logic                idx_en;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];

  song_note_counter #(.W(IDX_W)) u_idx (
    .clk   (clk),
    .rst_n (reset),
    .clr   (idx_clr),
    .en    (idx_en),
    .cnt   (idx),
    .tc    (idx_last)
  );

  always_comb begin
    state_d     = state_q;
    cur_song_d  = cur_song_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;
    idx_clr     = 1'b0;
    idx_en      = 1'b0;

    if (reset_play) begin
      state_d    = ST_IDLE;
      cur_song_d = song;
      note_d     = '0;
      dur_d      = '0;
      idx_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play) begin
            cur_song_d = song;
            state_d    = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (play) state_d = ST_WAIT_ROM;
        end
        ST_WAIT_ROM: begin
          if (rom_dur == DUR_W'(END_MARKER)) begin
            song_done_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            note_d     = rom_note;
            dur_d      = rom_dur;
            new_note_d = 1'b1;
            state_d    = ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // The last slot ends the song instead of wrapping the index.
          if (note_done) begin
            if (idx_last) begin
              song_done_d = 1'b1;
              state_d     = ST_DONE;
            end else begin
              idx_en  = 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          idx_clr = 1'b1;
          state_d = ST_END;
        end
        ST_END:  state_d = ST_END;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cur_song_q  <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_song_q  <= cur_song_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr  = {cur_song_q, idx};
  assign new_note  = new_note_q;
  assign note      = note_q;
  assign duration  = dur_q;
  assign song_done = song_done_q;

endmodule

`default_nettype wire

// File: tb/tb_song_reader.sv
// ---------------------------------------------------------------------------
// tb_song_reader : randomized-ROM bench for song_reader with a reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_song_reader;
  import song_reader_pkg::*;

  localparam int IW = DEF_IDX_W;
  localparam int NW = DEF_NOTE_W;
  localparam int DW = DEF_DUR_W;
  localparam int AW = SONG_W + IW;
  localparam int NOTES = 1 << IW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              reset_play = 1'b0;
  logic              play = 1'b0;
  logic [SONG_W-1:0] song = '0;
  logic              nd_auto = 1'b0;
  logic              nd_man = 1'b0;
  logic              note_done;
  logic [AW-1:0]     rom_addr;
  logic [NW+DW-1:0]  rom_data = '0;
  logic              new_note;
  logic [NW-1:0]     note;
  logic [DW-1:0]     duration;
  logic              song_done;

  logic [NW+DW-1:0]  rom_mem [0:(1<<AW)-1];

  assign note_done = nd_auto | nd_man;

  song_reader dut (
    .clk        (clk),
    .reset      (reset),
    .reset_play (reset_play),
    .play       (play),
    .song       (song),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .new_note   (new_note),
    .note       (note),
    .duration   (duration),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passes = 0, total = 0, fails = 0;
  bit resp_en = 1'b0;

  int          nn_cyc[$];
  logic [NW-1:0] nn_note[$];
  logic [DW-1:0] nn_dur[$];
  int          nd_cyc[$];
  int          sd_cyc[$];
  int          overlap = 0, consec = 0;
  logic        prev_nn = 1'b0, prev_sd = 1'b0;

  // Observe pulses mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (new_note) begin
        nn_cyc.push_back(cyc);
        nn_note.push_back(note);
        nn_dur.push_back(duration);
      end
      if (song_done) sd_cyc.push_back(cyc);
      if (note_done) nd_cyc.push_back(cyc);
      if (new_note && song_done) overlap++;
      if ((new_note && prev_nn) || (song_done && prev_sd)) consec++;
      prev_nn = new_note;
      prev_sd = song_done;
    end
  end

  // note_player stand-in: note_done five cycles after each new_note.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (new_note && resp_en) begin
        repeat (5) @(negedge clk);
        nd_auto = 1'b1;
        @(negedge clk);
        nd_auto = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a song plays every entry up to the first zero duration.
  function automatic int exp_len(input int s);
    for (int i = 0; i < NOTES; i++)
      if (rom_mem[s*NOTES+i][DW-1:0] == '0) return i;
    return NOTES;
  endfunction

  task automatic clear_q();
    nn_cyc.delete(); nn_note.delete(); nn_dur.delete();
    nd_cyc.delete(); sd_cyc.delete();
  endtask

  task automatic wait_nn(input int n, input int budget, input string tag);
    int k;
    for (k = 0; k < budget && nn_cyc.size() < n; k++) @(negedge clk);
    check(tag, 64'(nn_cyc.size() >= n), 64'd1);
  endtask

  task automatic wait_nd(input int n, input int budget, input string tag);
    int k;
    for (k = 0; k < budget && nd_cyc.size() < n; k++) @(negedge clk);
    check(tag, 64'(nd_cyc.size() >= n), 64'd1);
  endtask

  task automatic restart();
    reset_play = 1'b1;
    play       = 1'b0;
    @(negedge clk);
    reset_play = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_song(input int s);
    int n, p, k, exp_sd;
    logic [AW-1:0] end_addr;
    n = exp_len(s);
    clear_q();
    song    = SONG_W'(s);
    resp_en = 1'b1;
    play    = 1'b1;
    p       = cyc;
    for (k = 0; k < 3000 && sd_cyc.size() == 0; k++) @(negedge clk);
    check($sformatf("s%0d_done_seen", s), 64'(sd_cyc.size() != 0), 64'd1);
    repeat (20) @(negedge clk);
    check($sformatf("s%0d_nn_count", s), 64'(nn_cyc.size()), 64'(n));
    check($sformatf("s%0d_sd_count", s), 64'(sd_cyc.size()), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i < nn_cyc.size()) begin
        check($sformatf("s%0d_note%0d", s, i), 64'(nn_note[i]), 64'(rom_mem[s*NOTES+i][NW+DW-1:DW]));
        check($sformatf("s%0d_dur%0d", s, i), 64'(nn_dur[i]), 64'(rom_mem[s*NOTES+i][DW-1:0]));
        if (i == 0)
          check($sformatf("s%0d_lat0", s), 64'(nn_cyc[0]), 64'(p + 3));
        else if (i - 1 < nd_cyc.size())
          check($sformatf("s%0d_lat%0d", s, i), 64'(nn_cyc[i]), 64'(nd_cyc[i-1] + 3));
      end
    end
    if (sd_cyc.size() != 0 && nd_cyc.size() >= n) begin
      if (n == NOTES)  exp_sd = nd_cyc[NOTES-1] + 1;
      else if (n == 0) exp_sd = p + 3;
      else             exp_sd = nd_cyc[n-1] + 3;
      check($sformatf("s%0d_sd_cycle", s), 64'(sd_cyc[0]), 64'(exp_sd));
    end
    end_addr = rom_addr;
    check($sformatf("s%0d_end_addr", s), 64'(end_addr), 64'(s * NOTES));
    repeat (10) @(negedge clk);
    check($sformatf("s%0d_end_quiet", s), 64'(nn_cyc.size()), 64'(n));
    check($sformatf("s%0d_end_hold", s), 64'(rom_addr), 64'(end_addr));
    resp_en = 1'b0;
    restart();
  endtask

  initial begin
    int q;
    for (int a = 0; a < (1 << AW); a++)
      rom_mem[a] = {NW'($urandom), DW'($urandom_range(1, (1 << DW) - 1))};
    rom_mem[3][DW-1:0] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", 64'(rom_addr), 64'd0);
    check("rst_nn", 64'(new_note), 64'd0);
    check("rst_sd", 64'(song_done), 64'd0);
    check("rst_note", 64'(note), 64'd0);
    check("rst_dur", 64'(duration), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_nn", 64'(new_note), 64'd0);
    check("idle_addr", 64'(rom_addr), 64'd0);

    // First note of song 2
    song = 2'd2;
    play = 1'b1;
    @(negedge clk);
    check("fetch_addr", 64'(rom_addr), 64'd64);
    @(negedge clk);
    check("waitrom_nn", 64'(new_note), 64'd0);
    @(negedge clk);
    check("first_nn", 64'(new_note), 64'd1);
    check("first_note", 64'(note), 64'(rom_mem[64][NW+DW-1:DW]));
    check("first_dur", 64'(duration), 64'(rom_mem[64][DW-1:0]));
    restart();
    check("rp_note", 64'(note), 64'd0);
    check("rp_dur", 64'(duration), 64'd0);

    // Full 32-note song, then an early end marker
    run_song(1);
    run_song(0);

    // Pause during WAIT_DONE at idx 5
    clear_q();
    song    = 2'd3;
    resp_en = 1'b1;
    play    = 1'b1;
    wait_nn(6, 500, "pause_reach_idx5");
    play = 1'b0;
    wait_nd(6, 50, "pause_note_done");
    repeat (4) @(negedge clk);
    check("pause_nn_hold", 64'(nn_cyc.size()), 64'd6);
    check("pause_addr", 64'(rom_addr), 64'(3 * NOTES + 6));
    resp_en = 1'b0;
    q    = cyc;
    play = 1'b1;
    wait_nn(7, 20, "resume_nn");
    if (nn_cyc.size() >= 7) begin
      check("resume_lat", 64'(nn_cyc[6]), 64'(q + 2));
      check("resume_note", 64'(nn_note[6]), 64'(rom_mem[3*NOTES+6][NW+DW-1:DW]));
    end

    // reset_play together with note_done
    repeat (2) @(negedge clk);
    nd_man     = 1'b1;
    reset_play = 1'b1;
    @(negedge clk);
    nd_man     = 1'b0;
    reset_play = 1'b0;
    play       = 1'b0;
    check("rpnd_nn", 64'(new_note), 64'd0);
    check("rpnd_sd", 64'(song_done), 64'd0);
    check("rpnd_note", 64'(note), 64'd0);
    check("rpnd_addr", 64'(rom_addr), 64'(3 * NOTES));
    clear_q();
    repeat (6) @(negedge clk);
    check("rpnd_quiet_nn", 64'(nn_cyc.size()), 64'd0);
    check("rpnd_quiet_sd", 64'(sd_cyc.size()), 64'd0);
    check("rpnd_idle_addr", 64'(rom_addr), 64'(3 * NOTES));

    // Asynchronous reset while parked in FETCH
    clear_q();
    song    = 2'd1;
    resp_en = 1'b1;
    play    = 1'b1;
    wait_nd(1, 50, "async_first_done");
    play = 1'b0;
    repeat (2) @(negedge clk);
    check("async_pre_addr", 64'(rom_addr), 64'(NOTES + 1));
    check("async_pre_dur", 64'(duration), 64'(rom_mem[NOTES][DW-1:0]));
    #2 reset = 1'b0;
    #1;
    check("async_addr", 64'(rom_addr), 64'd0);
    check("async_note", 64'(note), 64'd0);
    check("async_dur", 64'(duration), 64'd0);
    check("async_nn", 64'(new_note), 64'd0);
    @(negedge clk);
    reset   = 1'b1;
    resp_en = 1'b0;
    repeat (3) @(negedge clk);

    check("pulse_overlap", 64'(overlap), 64'd0);
    check("pulse_consec", 64'(consec), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
